// File: rtl/hazard_tracker.sv
// Producer side of the forwarding interface: tracks destination/regwrite through EX, MEM and WB,
// and raises the pipeline stall for load-use hazards and for multi-cycle mul/div held in EX.
module hazard_tracker #(
  parameter int MULDIV_LAT = 4,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_muldiv,
  input  logic             flush,
  output logic             stall,
  output logic             muldiv_busy,
  output logic [REG_W-1:0] dec_ex_rd,
  output logic             dec_ex_regwrite,
  output logic [REG_W-1:0] ex_mem_rd,
  output logic             ex_mem_regwrite,
  output logic [REG_W-1:0] mem_wb_rd,
  output logic             mem_wb_regwrite
);

  localparam bit                 MULTI    = (MULDIV_LAT > 1);
  localparam int                 CNT_W    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [REG_W-1:0]   R_ZERO   = '0;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // EX needs all four fields; MEM and WB only carry what the bypass unit consumes.
  logic [REG_W-1:0] r_ex_rd;
  logic             r_ex_regwrite;
  logic             r_ex_memread;
  logic             r_ex_muldiv;
  logic [REG_W-1:0] r_mem_rd;
  logic             r_mem_regwrite;
  logic [REG_W-1:0] r_wb_rd;
  logic             r_wb_regwrite;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic w_ex_hit;
  logic w_load_use;
  logic w_hold_ex;
  logic w_stall;
  logic w_accept;

  assign w_ex_hit   = (r_ex_rd == id_rs) || (r_ex_rd == id_rt);
  assign w_load_use = id_valid && !flush && r_ex_memread && r_ex_regwrite &&
                      (r_ex_rd != R_ZERO) && w_ex_hit;
  assign w_hold_ex  = ((r_state == S_IDLE) && r_ex_muldiv && MULTI) ||
                      ((r_state == S_BUSY) && (r_cnt > CNT_ONE));
  assign w_stall    = w_load_use || w_hold_ex;
  assign w_accept   = id_valid && !w_stall && !flush;

  // Mul/div occupancy FSM; cnt counts the remaining held cycles once BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ex_muldiv && MULTI) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_muldiv    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      r_wb_rd       <= r_mem_rd;
      r_wb_regwrite <= r_mem_regwrite;
      if (w_hold_ex) begin
        // EX keeps the mul/div; a bubble slides out behind it.
        r_mem_rd       <= '0;
        r_mem_regwrite <= 1'b0;
      end else begin
        r_mem_rd       <= r_ex_rd;
        r_mem_regwrite <= r_ex_regwrite;
        if (w_accept) begin
          r_ex_rd       <= id_rd;
          r_ex_regwrite <= id_regwrite;
          r_ex_memread  <= id_memread;
          r_ex_muldiv   <= id_muldiv;
        end else begin
          r_ex_rd       <= '0;
          r_ex_regwrite <= 1'b0;
          r_ex_memread  <= 1'b0;
          r_ex_muldiv   <= 1'b0;
        end
      end
    end
  end

  // A write to r0 is architecturally a no-op, so it never advertises regwrite.
  assign stall           = w_stall;
  assign muldiv_busy     = r_busy;
  assign dec_ex_rd       = r_ex_rd;
  assign dec_ex_regwrite = r_ex_regwrite && (r_ex_rd != R_ZERO);
  assign ex_mem_rd       = r_mem_rd;
  assign ex_mem_regwrite = r_mem_regwrite && (r_mem_rd != R_ZERO);
  assign mem_wb_rd       = r_wb_rd;
  assign mem_wb_regwrite = r_wb_regwrite && (r_wb_rd != R_ZERO);

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: a vector table walked one cycle per row, then
// hand-written sequences for asynchronous reset mid-BUSY and recovery.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_regwrite, id_memread, id_muldiv, flush;
  logic       stall, muldiv_busy;
  logic [4:0] dec_ex_rd, ex_mem_rd, mem_wb_rd;
  logic       dec_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite;

  int total = 0;
  int bad   = 0;

  hazard_tracker #(.MULDIV_LAT(4), .REG_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_muldiv       (id_muldiv),
    .flush           (flush),
    .stall           (stall),
    .muldiv_busy     (muldiv_busy),
    .dec_ex_rd       (dec_ex_rd),
    .dec_ex_regwrite (dec_ex_regwrite),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite)
  );

  always #5 clk = ~clk;

  // Inputs held for one cycle, and the outputs expected during that same cycle.
  typedef struct {
    int v, rs, rt, rd, rw, mr, md, fl;
    int e_stall, e_busy, e_exrd, e_exrw, e_memrd, e_memrw, e_wbrd, e_wbrw;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int v, input int rs, input int rt, input int rd,
                       input int rw, input int mr, input int md, input int fl);
    id_valid    = 1'(v);
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_rd       = 5'(rd);
    id_regwrite = 1'(rw);
    id_memread  = 1'(mr);
    id_muldiv   = 1'(md);
    flush       = 1'(fl);
  endtask

  task automatic chk_all(input string tag, input int st, input int bz,
                         input int exrd, input int exrw, input int mrd, input int mrw,
                         input int wrd, input int wrw);
    chk({tag, ".stall"},   32'(stall), st);
    chk({tag, ".busy"},    32'(muldiv_busy), bz);
    chk({tag, ".ex_rd"},   32'(dec_ex_rd), exrd);
    chk({tag, ".ex_rw"},   32'(dec_ex_regwrite), exrw);
    chk({tag, ".mem_rd"},  32'(ex_mem_rd), mrd);
    chk({tag, ".mem_rw"},  32'(ex_mem_regwrite), mrw);
    chk({tag, ".wb_rd"},   32'(mem_wb_rd), wrd);
    chk({tag, ".wb_rw"},   32'(mem_wb_regwrite), wrw);
  endtask

  initial begin
    //              v rs rt rd rw mr md fl | st bz exrd exrw mrd mrw wrd wrw
    tbl.push_back('{1, 1, 2, 3, 1, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0}); // ALU rd=3
    tbl.push_back('{1, 5, 6, 4, 1, 0, 0, 0,  0, 0,  3, 1,  0, 0,  0, 0}); // ALU rd=4
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  4, 1,  3, 1,  0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0,  4, 1,  3, 1});
    tbl.push_back('{1, 1, 2, 8, 1, 1, 0, 0,  0, 0,  0, 0,  0, 0,  4, 1}); // lw r8
    tbl.push_back('{1, 8, 2,10, 1, 0, 0, 0,  1, 0,  8, 1,  0, 0,  0, 0}); // use r8: stall
    tbl.push_back('{1, 8, 2,10, 1, 0, 0, 0,  0, 0,  0, 0,  8, 1,  0, 0}); // released
    tbl.push_back('{1, 1, 1, 7, 1, 1, 0, 0,  0, 0, 10, 1,  0, 0,  8, 1}); // lw r7
    tbl.push_back('{1, 3, 7,11, 1, 0, 0, 1,  0, 0,  7, 1, 10, 1,  0, 0}); // use r7 + flush
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0,  7, 1, 10, 1});
    tbl.push_back('{1, 1, 2, 0, 1, 1, 0, 0,  0, 0,  0, 0,  0, 0,  7, 1}); // lw r0
    tbl.push_back('{1, 0, 0,12, 1, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0}); // use r0: no stall
    tbl.push_back('{1, 1, 2, 9, 1, 0, 1, 0,  0, 0, 12, 1,  0, 0,  0, 0}); // mul rd=9
    tbl.push_back('{1, 1, 2, 5, 1, 0, 0, 0,  1, 0,  9, 1, 12, 1,  0, 0}); // held, IDLE
    tbl.push_back('{1, 1, 2, 5, 1, 0, 0, 0,  1, 1,  9, 1,  0, 0, 12, 1});
    tbl.push_back('{1, 1, 2, 5, 1, 0, 0, 0,  1, 1,  9, 1,  0, 0,  0, 0});
    tbl.push_back('{1, 1, 2, 5, 1, 0, 0, 0,  0, 1,  9, 1,  0, 0,  0, 0}); // last BUSY
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  5, 1,  9, 1,  0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0,  5, 1,  9, 1});
    tbl.push_back('{1, 1, 2,13, 1, 0, 1, 0,  0, 0,  0, 0,  0, 0,  5, 1}); // mul rd=13
    tbl.push_back('{1, 1, 2,14, 1, 0, 1, 0,  1, 0, 13, 1,  0, 0,  0, 0}); // mul rd=14 waits
    tbl.push_back('{1, 1, 2,14, 1, 0, 1, 0,  1, 1, 13, 1,  0, 0,  0, 0});
    tbl.push_back('{1, 1, 2,14, 1, 0, 1, 0,  1, 1, 13, 1,  0, 0,  0, 0});
    tbl.push_back('{1, 1, 2,14, 1, 0, 1, 0,  0, 1, 13, 1,  0, 0,  0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 14, 1, 13, 1,  0, 0}); // re-triggered
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 14, 1,  0, 0, 13, 1});

    // Reset state, with busy-looking ID inputs present.
    reset = 1'b1;
    drive(1, 0, 0, 9, 1, 1, 1, 0);
    repeat (2) @(negedge clk);
    #4;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    $display("reset: stall=%0b busy=%0b", stall, muldiv_busy);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].md, tbl[i].fl);
      #4;
      chk_all($sformatf("row%0d", i), tbl[i].e_stall, tbl[i].e_busy,
              tbl[i].e_exrd, tbl[i].e_exrw, tbl[i].e_memrd, tbl[i].e_memrw,
              tbl[i].e_wbrd, tbl[i].e_wbrw);
      $display("row %0d: stall=%0b busy=%0b ex=%0d/%0b mem=%0d/%0b wb=%0d/%0b", i,
               stall, muldiv_busy, dec_ex_rd, dec_ex_regwrite,
               ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);
      @(negedge clk);
    end

    // Second BUSY cycle of the rd=14 mul/div: reset drops everything without an edge.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_all("prereset", 1, 1, 14, 1, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    $display("async reset: stall=%0b busy=%0b ex_rw=%0b", stall, muldiv_busy, dec_ex_regwrite);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #4;
    chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // FSM starts from IDLE again: a fresh mul/div holds from IDLE, then BUSY.
    @(negedge clk);
    drive(1, 1, 2, 6, 1, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("recover.stall", 32'(stall), 1);
    chk("recover.busy",  32'(muldiv_busy), 0);
    @(negedge clk);
    #4;
    chk("recover.busy2", 32'(muldiv_busy), 1);
    $display("recover: stall=%0b busy=%0b ex=%0d", stall, muldiv_busy, dec_ex_rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
